// File: rtl/tetris_stat_pkg.sv
// Shared types and constants for the game statistics sequencer:
// FSM encoding, BCD digit type, per-clear base score table and line clamp.
package tetris_stat_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LINES = 3'd1,
        SCORE = 3'd2,
        LEVEL = 3'd3,
        DONE  = 3'd4
    } stat_state_e;

    typedef logic [3:0] bcd_digit_t;

    // Base points for 0..4 cleared lines, BCD-coded, in units of the dropped zero digits.
    localparam logic [7:0] BASE_SCORE [0:4] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h15};

    function automatic logic [2:0] clamp_lines(input logic [2:0] n);
        logic [2:0] r;
        if (n > 3'd4) begin
            r = 3'd4;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_sat_add.sv
// Combinational multi-digit BCD adder; any carry out of the top digit
// saturates the result to all nines.
module bcd_sat_add
    import tetris_stat_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGITS*4-1:0] a,
    input  logic [DIGITS*4-1:0] b,
    output logic [DIGITS*4-1:0] sum
);

    logic [DIGITS*4-1:0] raw_s;
    logic [4:0]          dsum_s;
    logic                carry_s;

    // Ripple digit-wise decimal addition, then saturate on final carry.
    always_comb begin
        raw_s   = '0;
        dsum_s  = 5'd0;
        carry_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dsum_s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, carry_s};
            if (dsum_s > 5'd9) begin
                raw_s[i*4 +: 4] = bcd_digit_t'(dsum_s - 5'd10);
                carry_s         = 1'b1;
            end else begin
                raw_s[i*4 +: 4] = bcd_digit_t'(dsum_s);
                carry_s         = 1'b0;
            end
        end
        if (carry_s) begin
            sum = {DIGITS{4'h9}};
        end else begin
            sum = raw_s;
        end
    end

endmodule

// File: rtl/tetris_stat_seq.sv
// Handshaked game statistics sequencer: BCD score, lines, level and session
// high score, with score per clear built by repeated BCD addition.
module tetris_stat_seq
    import tetris_stat_pkg::*;
#(
    parameter int SCORE_DIGITS    = 6,
    parameter int SCORE_ZEROS     = 2,
    parameter int LINES_DIGITS    = 4,
    parameter int LEVEL_DIGITS    = 2,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 99
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   new_game_i,
    input  logic [6:0]                             start_level_i,
    input  logic                                   upd_valid_i,
    input  logic [2:0]                             upd_lines_i,
    output logic                                   upd_ready_o,
    output logic                                   upd_done_o,
    output logic [(SCORE_DIGITS+SCORE_ZEROS)*4-1:0] score_o,
    output logic [(SCORE_DIGITS+SCORE_ZEROS)*4-1:0] hiscore_o,
    output logic [LINES_DIGITS*4-1:0]              lines_o,
    output logic [LEVEL_DIGITS*4-1:0]              level_o,
    output logic [6:0]                             level_bin_o,
    output logic                                   level_changed_o
);

    localparam int SW  = SCORE_DIGITS * 4;
    localparam int LW  = LINES_DIGITS * 4;
    localparam int LVW = LEVEL_DIGITS * 4;
    localparam logic [LVW-1:0] LEVEL_ONE = LVW'(4'h1);

    function automatic logic [LVW-1:0] level_to_bcd(input logic [6:0] v);
        logic [LVW-1:0] r;
        logic [6:0]     t;
        r = '0;
        t = v;
        for (int i = 0; i < LEVEL_DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 7'd10);
            t           = t / 7'd10;
        end
        return r;
    endfunction

    stat_state_e    state_r, state_s;
    logic [2:0]     n_r;
    logic [7:0]     cnt_r;
    logic [SW-1:0]  score_r, hiscore_r, score_sum_s, base_s;
    logic [LW-1:0]  lines_r, lines_sum_s, lines_add_s;
    logic [LVW-1:0] level_r, level_inc_s;
    logic [6:0]     level_bin_r, lil_r, lil_sum_s, lvl_start_s;
    logic           level_up_s, done_r, lvl_chg_r;

    assign base_s      = SW'(BASE_SCORE[n_r]);
    assign lines_add_s = LW'(n_r);
    assign lil_sum_s   = lil_r + 7'(n_r);
    assign level_up_s  = (lil_sum_s >= 7'(LINES_PER_LEVEL));
    assign lvl_start_s = (start_level_i > 7'(MAX_LEVEL)) ? 7'(MAX_LEVEL) : start_level_i;

    bcd_sat_add #(.DIGITS(SCORE_DIGITS)) u_score_add (.a(score_r), .b(base_s),      .sum(score_sum_s));
    bcd_sat_add #(.DIGITS(LINES_DIGITS)) u_lines_add (.a(lines_r), .b(lines_add_s), .sum(lines_sum_s));
    bcd_sat_add #(.DIGITS(LEVEL_DIGITS)) u_level_add (.a(level_r), .b(LEVEL_ONE),   .sum(level_inc_s));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a new game forces IDLE from anywhere.
    always_comb begin
        state_s = state_r;
        if (new_game_i) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = upd_valid_i ? LINES : IDLE;
                LINES:   state_s = (n_r == 3'd0) ? LEVEL : SCORE;
                SCORE:   state_s = (cnt_r <= 8'd1) ? LEVEL : SCORE;
                LEVEL:   state_s = DONE;
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Statistics datapath; hiscore and the done pulse commit on entry to DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_r         <= 3'd0;
            cnt_r       <= 8'd0;
            score_r     <= '0;
            hiscore_r   <= '0;
            lines_r     <= '0;
            level_r     <= '0;
            level_bin_r <= 7'd0;
            lil_r       <= 7'd0;
            done_r      <= 1'b0;
            lvl_chg_r   <= 1'b0;
        end else if (new_game_i) begin
            score_r     <= '0;
            lines_r     <= '0;
            lil_r       <= 7'd0;
            level_bin_r <= lvl_start_s;
            level_r     <= level_to_bcd(lvl_start_s);
            done_r      <= 1'b0;
            lvl_chg_r   <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            lvl_chg_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (upd_valid_i) begin
                        n_r <= clamp_lines(upd_lines_i);
                    end
                end
                LINES: begin
                    lines_r <= lines_sum_s;
                    cnt_r   <= 8'(level_bin_r) + 8'd1;
                end
                SCORE: begin
                    score_r <= score_sum_s;
                    cnt_r   <= cnt_r - 8'd1;
                end
                LEVEL: begin
                    if (level_up_s) begin
                        lil_r <= lil_sum_s - 7'(LINES_PER_LEVEL);
                        if (level_bin_r < 7'(MAX_LEVEL)) begin
                            level_bin_r <= level_bin_r + 7'd1;
                            level_r     <= level_inc_s;
                            lvl_chg_r   <= 1'b1;
                        end
                    end else begin
                        lil_r <= lil_sum_s;
                    end
                    if (score_r > hiscore_r) begin
                        hiscore_r <= score_r;
                    end
                    done_r <= 1'b1;
                end
                DONE: begin
                    n_r <= n_r;
                end
                default: begin
                    n_r <= 3'd0;
                end
            endcase
        end
    end

    assign upd_ready_o     = (state_r == IDLE);
    assign upd_done_o      = done_r;
    assign level_changed_o = lvl_chg_r;
    assign score_o         = {score_r, {(SCORE_ZEROS*4){1'b0}}};
    assign hiscore_o       = {hiscore_r, {(SCORE_ZEROS*4){1'b0}}};
    assign lines_o         = lines_r;
    assign level_o         = level_r;
    assign level_bin_o     = level_bin_r;

endmodule

// File: tb/tb_tetris_stat_seq.sv
// Self-checking bench for tetris_stat_seq: directed table, hand sequences for
// abort/saturation/hiscore, and random updates against an arithmetic model.
module tb_tetris_stat_seq;

    localparam int SD   = 4;
    localparam int SZ   = 2;
    localparam int LD   = 4;
    localparam int VD   = 2;
    localparam int LPL  = 10;
    localparam int MAXL = 99;
    localparam int SMAX = 9999;
    localparam int LMAX = 9999;

    logic              clk = 1'b0;
    logic              rst_n, new_game, upd_valid;
    logic [6:0]        start_level;
    logic [2:0]        upd_lines;
    logic              upd_ready_o, upd_done_o, level_changed_o;
    logic [(SD+SZ)*4-1:0] score_o, hiscore_o;
    logic [LD*4-1:0]   lines_o;
    logic [VD*4-1:0]   level_o;
    logic [6:0]        level_bin_o;

    int n_cmp = 0;
    int n_bad = 0;
    int m_score, m_hi, m_lines, m_lvl, m_lil;
    int base_tab[5] = '{0, 1, 3, 7, 15};

    typedef struct {
        bit          ng;
        int          sl;
        logic [2:0]  n;
        logic [23:0] score;
        logic [15:0] lines;
        logic [7:0]  level;
        int          lat;
        int          pulse;
    } vec_t;
    vec_t vt[8];

    tetris_stat_seq #(
        .SCORE_DIGITS(SD), .SCORE_ZEROS(SZ), .LINES_DIGITS(LD),
        .LEVEL_DIGITS(VD), .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAXL)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .new_game_i(new_game),
        .start_level_i(start_level), .upd_valid_i(upd_valid),
        .upd_lines_i(upd_lines), .upd_ready_o(upd_ready_o),
        .upd_done_o(upd_done_o), .score_o(score_o), .hiscore_o(hiscore_o),
        .lines_o(lines_o), .level_o(level_o), .level_bin_o(level_bin_o),
        .level_changed_o(level_changed_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] score_bcd(input int units);
        logic [31:0] t;
        t = to_bcd(units);
        return {t[15:0], 8'h00};
    endfunction

    function automatic logic [7:0] level_bcd(input int v);
        logic [31:0] t;
        t = to_bcd(v);
        return t[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_score"}, score_o, score_bcd(m_score));
        check({tag, "_hiscore"}, hiscore_o, score_bcd(m_hi));
        check({tag, "_lines"}, lines_o, to_bcd(m_lines));
        check({tag, "_level"}, level_o, level_bcd(m_lvl));
        check({tag, "_level_bin"}, level_bin_o, m_lvl);
        check({tag, "_ready"}, upd_ready_o, 1);
    endtask

    task automatic do_new_game(input int sl);
        @(negedge clk);
        new_game = 1'b1;
        start_level = 7'(sl);
        @(negedge clk);
        new_game = 1'b0;
        m_score = 0;
        m_lines = 0;
        m_lil = 0;
        m_lvl = (sl > MAXL) ? MAXL : sl;
        check("ng_done", upd_done_o, 0);
        check_state("ng");
    endtask

    task automatic do_update(input logic [2:0] n_raw, output int lat, output int pulses);
        int n, exp_lat, exp_pulse;
        bit ready_bad;
        n = (n_raw > 3'd4) ? 4 : int'(n_raw);
        exp_lat = (n == 0) ? 3 : 4 + m_lvl;
        m_lines = (m_lines + n > LMAX) ? LMAX : m_lines + n;
        if (n > 0) begin
            m_score = m_score + base_tab[n] * (m_lvl + 1);
            if (m_score > SMAX) m_score = SMAX;
        end
        m_lil += n;
        exp_pulse = 0;
        if (m_lil >= LPL) begin
            m_lil -= LPL;
            if (m_lvl < MAXL) begin
                m_lvl++;
                exp_pulse = 1;
            end
        end
        if (m_score > m_hi) m_hi = m_score;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_lines = n_raw;
        @(negedge clk);
        upd_valid = 1'b0;
        lat = 1;
        pulses = 0;
        ready_bad = 1'b0;
        while (!upd_done_o && lat < 300) begin
            if (upd_ready_o) ready_bad = 1'b1;
            if (level_changed_o) pulses++;
            @(negedge clk);
            lat++;
        end
        if (level_changed_o) pulses++;
        check("latency", lat, exp_lat);
        check("ready_busy", 32'(ready_bad), 0);
        check("lvl_pulse", pulses, exp_pulse);
        check("hiscore_at_done", hiscore_o, score_bcd(m_hi));
        @(negedge clk);
        check("done_width", upd_done_o, 0);
        check_state("upd");
    endtask

    int lat, pul, dcount;

    initial begin
        rst_n = 1'b0;
        new_game = 1'b0;
        upd_valid = 1'b0;
        start_level = 7'd0;
        upd_lines = 3'd0;
        m_score = 0; m_hi = 0; m_lines = 0; m_lvl = 0; m_lil = 0;
        vt[0] = '{1'b1, 0,   3'd4, 24'h001500, 16'h0004, 8'h00, 4,   0};
        vt[1] = '{1'b1, 9,   3'd2, 24'h003000, 16'h0002, 8'h09, 13,  0};
        vt[2] = '{1'b1, 0,   3'd4, 24'h001500, 16'h0004, 8'h00, 4,   0};
        vt[3] = '{1'b0, 0,   3'd4, 24'h003000, 16'h0008, 8'h00, 4,   0};
        vt[4] = '{1'b0, 0,   3'd3, 24'h003700, 16'h0011, 8'h01, 4,   1};
        vt[5] = '{1'b0, 0,   3'd7, 24'h006700, 16'h0015, 8'h01, 5,   0};
        vt[6] = '{1'b0, 0,   3'd0, 24'h006700, 16'h0015, 8'h01, 3,   0};
        vt[7] = '{1'b1, 120, 3'd1, 24'h010000, 16'h0001, 8'h99, 103, 0};

        repeat (2) @(negedge clk);
        check("rst_done", upd_done_o, 0);
        check("rst_lvl_chg", level_changed_o, 0);
        check_state("rst");
        rst_n = 1'b1;

        // Session best survives a new game and tracks the better game.
        do_new_game(0);
        repeat (3) do_update(3'd4, lat, pul);
        check("g1_hiscore", hiscore_o, 24'h004500);
        do_new_game(0);
        do_update(3'd4, lat, pul);
        check("g2_hiscore_kept", hiscore_o, 24'h004500);
        check("g2_score", score_o, 24'h001500);
        do_update(3'd4, lat, pul);
        do_update(3'd1, lat, pul);
        do_update(3'd4, lat, pul);
        check("g2_hiscore_new", hiscore_o, 24'h004600);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].ng) do_new_game(vt[i].sl);
            do_update(vt[i].n, lat, pul);
            check($sformatf("tbl%0d_score", i), score_o, vt[i].score);
            check($sformatf("tbl%0d_lines", i), lines_o, vt[i].lines);
            check($sformatf("tbl%0d_level", i), level_o, vt[i].level);
            check($sformatf("tbl%0d_lat", i), lat, vt[i].lat);
            check($sformatf("tbl%0d_pulse", i), pul, vt[i].pulse);
        end

        // Score saturation and no level pulse at the ceiling.
        do_new_game(99);
        repeat (8) do_update(3'd4, lat, pul);
        check("sat_score", score_o, 24'h999900);
        check("sat_level", level_o, 8'h99);

        // New game during SCORE aborts the update with no done pulse.
        do_new_game(50);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_lines = 3'd2;
        @(negedge clk);
        upd_valid = 1'b0;
        repeat (2) @(negedge clk);
        do_new_game(0);
        dcount = 0;
        repeat (80) begin
            @(negedge clk);
            if (upd_done_o) dcount++;
        end
        check("abort_no_done", dcount, 0);
        repeat (2) do_update(3'd4, lat, pul);
        do_update(3'd3, lat, pul);
        check("abort_lil_pulse", pul, 1);

        // New game beats a simultaneous request.
        @(negedge clk);
        new_game = 1'b1;
        start_level = 7'd0;
        upd_valid = 1'b1;
        upd_lines = 3'd4;
        @(negedge clk);
        new_game = 1'b0;
        upd_valid = 1'b0;
        m_score = 0; m_lines = 0; m_lil = 0; m_lvl = 0;
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (upd_done_o) dcount++;
        end
        check("ngv_no_done", dcount, 0);
        check_state("ngv");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7) == 0) begin
                do_new_game(int'($urandom_range(127)));
            end else begin
                do_update(3'($urandom_range(7)), lat, pul);
            end
        end

        // Asynchronous reset in the middle of an update.
        do_new_game(20);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_lines = 3'd4;
        @(negedge clk);
        upd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_score = 0; m_hi = 0; m_lines = 0; m_lvl = 0; m_lil = 0;
        check("arst_done", upd_done_o, 0);
        check("arst_lvl_chg", level_changed_o, 0);
        check_state("arst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
